// File: rtl/id_ex_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline-stage definitions: default field widths, the packed
// control-bundle type carried between stages, and the bubble helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int PC_W_DEF     = 30;
    localparam int REG_W_DEF    = 5;
    localparam int ALUCTR_W_DEF = 3;

    typedef struct packed {
        logic                    RegWr;
        logic                    RegDst;
        logic                    ALUsrc;
        logic                    Branch;
        logic                    Jump;
        logic                    MemWr;
        logic                    MemtoReg;
        logic [ALUCTR_W_DEF-1:0] ALUctr;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // A bubble only kills the bits with architectural side effects; the
    // datapath-steering bits (RegDst, ALUsrc, ALUctr) are left as they were
    // so the bubble does not toggle the EX datapath for nothing.
    function automatic ctrl_t bubble_ctrl(input ctrl_t c);
        ctrl_t b;
        b          = c;
        b.RegWr    = CTRL_BUBBLE.RegWr;
        b.Branch   = CTRL_BUBBLE.Branch;
        b.Jump     = CTRL_BUBBLE.Jump;
        b.MemWr    = CTRL_BUBBLE.MemWr;
        b.MemtoReg = CTRL_BUBBLE.MemtoReg;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// ID/EX boundary bundle.
//   master : decode/control side; drives stall, flush and the id_* fields,
//            observes the ex_* fields and id_hold.
//   slave  : the pipeline register itself.
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int ALUCTR_W = ALUCTR_W_DEF
);
    logic                stall;
    logic                flush;

    logic                id_valid;
    logic [PC_W-1:0]     id_PC_plus_4;
    logic [DATA_W-1:0]   id_busA;
    logic [DATA_W-1:0]   id_busB;
    logic [DATA_W-1:0]   id_imm16Ext;
    logic [REG_W-1:0]    id_Ra;
    logic [REG_W-1:0]    id_Rb;
    logic [REG_W-1:0]    id_Rw;
    logic                id_UsesRb;
    logic                id_RegWr;
    logic                id_RegDst;
    logic                id_ALUsrc;
    logic                id_Branch;
    logic                id_Jump;
    logic                id_MemWr;
    logic                id_MemtoReg;
    logic [ALUCTR_W-1:0] id_ALUctr;

    logic                ex_valid;
    logic [PC_W-1:0]     ex_PC_plus_4;
    logic [DATA_W-1:0]   ex_busA;
    logic [DATA_W-1:0]   ex_busB;
    logic [DATA_W-1:0]   ex_imm16Ext;
    logic [REG_W-1:0]    ex_Ra;
    logic [REG_W-1:0]    ex_Rb;
    logic [REG_W-1:0]    ex_Rw;
    logic                ex_RegWr;
    logic                ex_RegDst;
    logic                ex_ALUsrc;
    logic                ex_Branch;
    logic                ex_Jump;
    logic                ex_MemWr;
    logic                ex_MemtoReg;
    logic [ALUCTR_W-1:0] ex_ALUctr;

    logic                id_hold;

    modport master (
        output stall, flush, id_valid, id_PC_plus_4, id_busA, id_busB,
               id_imm16Ext, id_Ra, id_Rb, id_Rw, id_UsesRb, id_RegWr,
               id_RegDst, id_ALUsrc, id_Branch, id_Jump, id_MemWr,
               id_MemtoReg, id_ALUctr,
        input  ex_valid, ex_PC_plus_4, ex_busA, ex_busB, ex_imm16Ext,
               ex_Ra, ex_Rb, ex_Rw, ex_RegWr, ex_RegDst, ex_ALUsrc,
               ex_Branch, ex_Jump, ex_MemWr, ex_MemtoReg, ex_ALUctr, id_hold
    );

    modport slave (
        input  stall, flush, id_valid, id_PC_plus_4, id_busA, id_busB,
               id_imm16Ext, id_Ra, id_Rb, id_Rw, id_UsesRb, id_RegWr,
               id_RegDst, id_ALUsrc, id_Branch, id_Jump, id_MemWr,
               id_MemtoReg, id_ALUctr,
        output ex_valid, ex_PC_plus_4, ex_busA, ex_busB, ex_imm16Ext,
               ex_Ra, ex_Rb, ex_Rw, ex_RegWr, ex_RegDst, ex_ALUsrc,
               ex_Branch, ex_Jump, ex_MemWr, ex_MemtoReg, ex_ALUctr, id_hold
    );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use compare between a producer stage (a load
// whose result is not yet available) and a consumer in decode.
// Ports:
//   i_ex_valid, i_ex_MemtoReg, i_ex_Rw : producer stage
//   i_id_valid, i_id_Ra, i_id_Rb, i_id_UsesRb : consumer in decode
//   o_load_use : consumer must wait one cycle
// ---------------------------------------------------------------------------
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_MemtoReg,
    input  logic [REG_W-1:0] i_ex_Rw,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_Ra,
    input  logic [REG_W-1:0] i_id_Rb,
    input  logic             i_id_UsesRb,
    output logic             o_load_use
);
    logic w_prod;
    logic w_match;

    // r0 is hardwired to zero, so a load targeting it never produces data.
    assign w_prod     = i_ex_valid & i_ex_MemtoReg & (i_ex_Rw != '0) & i_id_valid;
    assign w_match    = (i_ex_Rw == i_id_Ra) | (i_id_UsesRb & (i_ex_Rw == i_id_Rb));
    assign o_load_use = w_prod & w_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register with valid tracking, stall hold, flush-to-bubble
// and a built-in load-use bubble.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : id_ex_pipe_reg_if.slave (stall/flush, id_* in, ex_* out,
//                id_hold out)
//   perf_stall_cnt, perf_bubble_cnt : saturating 16-bit event counters,
//                present only when ID_EX_PERF_EN is defined
// Edge priority: flush > stall > load-use bubble > normal load.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic               Clk,
    input  logic               Rst_n,
    id_ex_pipe_reg_if.slave    bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]        perf_stall_cnt,
    output logic [15:0]        perf_bubble_cnt
`endif
);
    logic              r_valid;
    logic [PC_W-1:0]   r_pc4;
    logic [DATA_W-1:0] r_busA;
    logic [DATA_W-1:0] r_busB;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_Ra;
    logic [REG_W-1:0]  r_Rb;
    logic [REG_W-1:0]  r_Rw;
    ctrl_t             r_ctrl;

    ctrl_t             w_id_ctrl;
    logic              w_load_use;
    logic              w_bubble;

    always_comb begin
        w_id_ctrl          = CTRL_BUBBLE;
        w_id_ctrl.RegWr    = bus.id_RegWr;
        w_id_ctrl.RegDst   = bus.id_RegDst;
        w_id_ctrl.ALUsrc   = bus.id_ALUsrc;
        w_id_ctrl.Branch   = bus.id_Branch;
        w_id_ctrl.Jump     = bus.id_Jump;
        w_id_ctrl.MemWr    = bus.id_MemWr;
        w_id_ctrl.MemtoReg = bus.id_MemtoReg;
        w_id_ctrl.ALUctr   = bus.id_ALUctr;
    end

    // Compared against the registered EX contents, so during a stall the
    // check keeps looking at the frozen instruction.
    load_use_detect #(.REG_W(REG_W)) u_lud (
        .i_ex_valid    (r_valid),
        .i_ex_MemtoReg (r_ctrl.MemtoReg),
        .i_ex_Rw       (r_Rw),
        .i_id_valid    (bus.id_valid),
        .i_id_Ra       (bus.id_Ra),
        .i_id_Rb       (bus.id_Rb),
        .i_id_UsesRb   (bus.id_UsesRb),
        .o_load_use    (w_load_use)
    );

    // Stall outranks the load-use bubble; flush outranks both.
    assign w_bubble = bus.flush | (~bus.stall & w_load_use);

    // ID is being discarded on flush, so there is nothing to hold.
    assign bus.id_hold = ~bus.flush & (bus.stall | w_load_use);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_valid <= 1'b0;
            r_pc4   <= '0;
            r_busA  <= '0;
            r_busB  <= '0;
            r_imm   <= '0;
            r_Ra    <= '0;
            r_Rb    <= '0;
            r_Rw    <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= bubble_ctrl(r_ctrl);
        end else if (!bus.stall) begin
            r_valid <= bus.id_valid;
            r_pc4   <= bus.id_PC_plus_4;
            r_busA  <= bus.id_busA;
            r_busB  <= bus.id_busB;
            r_imm   <= bus.id_imm16Ext;
            r_Ra    <= bus.id_Ra;
            r_Rb    <= bus.id_Rb;
            r_Rw    <= bus.id_Rw;
            r_ctrl  <= w_id_ctrl;
        end
    end

    assign bus.ex_valid     = r_valid;
    assign bus.ex_PC_plus_4 = r_pc4;
    assign bus.ex_busA      = r_busA;
    assign bus.ex_busB      = r_busB;
    assign bus.ex_imm16Ext  = r_imm;
    assign bus.ex_Ra        = r_Ra;
    assign bus.ex_Rb        = r_Rb;
    assign bus.ex_Rw        = r_Rw;
    assign bus.ex_RegWr     = r_ctrl.RegWr;
    assign bus.ex_RegDst    = r_ctrl.RegDst;
    assign bus.ex_ALUsrc    = r_ctrl.ALUsrc;
    assign bus.ex_Branch    = r_ctrl.Branch;
    assign bus.ex_Jump      = r_ctrl.Jump;
    assign bus.ex_MemWr     = r_ctrl.MemWr;
    assign bus.ex_MemtoReg  = r_ctrl.MemtoReg;
    assign bus.ex_ALUctr    = r_ctrl.ALUctr;

`ifdef ID_EX_PERF_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_bubble;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (bus.stall && !bus.flush && r_perf_stall != 16'hFFFF)
                r_perf_stall <= r_perf_stall + 16'd1;
            if (w_bubble && r_perf_bubble != 16'hFFFF)
                r_perf_bubble <= r_perf_bubble + 16'd1;
        end
    end

    assign perf_stall_cnt  = r_perf_stall;
    assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule
